// File: rtl/bufram_reorder_pp.sv
// Ping-pong reorder buffer: natural-order writes into one bank, permuted reads (natural/rotate/bit-reverse) from the other.
// Latency: slot j of frame k is on DOR/DOI after ED edge (k+1)*N+j; RDY marks the first output after START.
// Backpressure: none; ED gates every state change, so the stream stalls in place while ED is low.
module bufram_reorder_pp #(
    parameter int NB   = 16,
    parameter int LOGN = 5,
    parameter int ROT  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ED,
    input  logic            START,
    input  logic [1:0]      MODE,
    input  logic [NB-1:0]   DR,
    input  logic [NB-1:0]   DI,
    output logic            RDY,
    output logic [NB-1:0]   DOR,
    output logic [NB-1:0]   DOI,
    output logic [LOGN-1:0] OIDX
);

    localparam int N = 1 << LOGN;
    localparam logic [LOGN+1:0] CT_SAT = (LOGN+2)'(N + 1);
    localparam logic [LOGN+1:0] CT_RDY = (LOGN+2)'(N);

    logic [LOGN:0]    addr_q, addr_d;
    logic [LOGN+1:0]  ct_q, ct_d;
    logic [1:0]       mode_q, mode_d;
    logic             rdy_q, rdy_d;
    logic [LOGN-1:0]  oidx_q, oidx_d;
    logic [2*NB-1:0]  rd_dat_q;

    logic             wr_en;
    logic             rd_en;
    logic [LOGN-1:0]  rd_slot;
    logic [LOGN:0]    rd_addr;

    logic [2*NB-1:0]  mem [2*N];

    function automatic logic [LOGN-1:0] perm(input logic [LOGN-1:0] j, input logic [1:0] m);
        logic [LOGN-1:0] p;
        p = j;
        case (m)
            2'd1:    p = (j >> ROT) | (j << (LOGN - ROT));
            2'd2:    p = {<<{j}};
            default: p = j;
        endcase
        return p;
    endfunction

    // The read slot is the write index; reads always hit the bank not being written.
    assign rd_slot = perm(addr_q[LOGN-1:0], mode_q);
    assign rd_addr = {~addr_q[LOGN], rd_slot};

    always_comb begin
        addr_d = addr_q;
        ct_d   = ct_q;
        mode_d = mode_q;
        rdy_d  = 1'b0;
        oidx_d = oidx_q;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        if (!RST) begin
            if (START) begin
                addr_d = '0;
                ct_d   = '0;
                mode_d = MODE;
            end else if (ED) begin
                wr_en  = 1'b1;
                rd_en  = 1'b1;
                oidx_d = rd_slot;
                addr_d = addr_q + (LOGN+1)'(1);
                if (ct_q != CT_SAT) begin
                    ct_d = ct_q + (LOGN+2)'(1);
                end
                rdy_d = (ct_q == CT_RDY);
                // Mode sampled on the last write of a frame governs that frame's readout.
                if (&addr_q[LOGN-1:0]) begin
                    mode_d = MODE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= '0;
            ct_q   <= CT_SAT;
            mode_q <= '0;
            rdy_q  <= 1'b0;
            oidx_q <= '0;
        end else begin
            addr_q <= addr_d;
            ct_q   <= ct_d;
            mode_q <= mode_d;
            rdy_q  <= rdy_d;
            oidx_q <= oidx_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[addr_q] <= {DR, DI};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_dat_q <= '0;
        end else if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign RDY  = rdy_q;
    assign DOR  = rd_dat_q[2*NB-1:NB];
    assign DOI  = rd_dat_q[NB-1:0];
    assign OIDX = oidx_q;

endmodule

// File: tb/tb_bufram_reorder_pp.sv
// Scoreboard bench for bufram_reorder_pp (N=16, ROT=2): directed frames push expected readouts,
// an independent monitor pops and compares on every ED edge and checks hold/reset behaviour otherwise.
module tb_bufram_reorder_pp;

    localparam int NB = 16;
    localparam int LOGN = 4;
    localparam int N = 16;

    logic            CLK;
    logic            RST;
    logic            ED;
    logic            START;
    logic [1:0]      MODE;
    logic [NB-1:0]   DR;
    logic [NB-1:0]   DI;
    logic            RDY;
    logic [NB-1:0]   DOR;
    logic [NB-1:0]   DOI;
    logic [LOGN-1:0] OIDX;

    bufram_reorder_pp #(.NB(NB), .LOGN(LOGN), .ROT(2)) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START), .MODE(MODE),
        .DR(DR), .DI(DI), .RDY(RDY), .DOR(DOR), .DOI(DOI), .OIDX(OIDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          n;
        logic [15:0] dor;
        logic [15:0] doi;
        logic [3:0]  oidx;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    // Hand-derived slot orders for N=16: {j[1:0], j[3:2]} and bit reversal.
    int rot_t [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int rev_t [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    int n_chk = 0;
    int n_pass = 0;
    int drv_cnt = 0;
    int mon_cnt = 0;
    int rdy_seen = 0;

    task automatic check(input string nm, input logic [36:0] act, input logic [36:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc(input logic ed, input logic st, input logic rs, input logic [1:0] md,
                       input int dr, input int di);
        @(negedge CLK);
        ED = ed; START = st; RST = rs; MODE = md;
        DR = 16'(dr); DI = 16'(di);
        if (ed && !st && !rs) drv_cnt++;
    endtask

    // sel: 0 natural, 1 rotate, 2 bit-reverse. Readout begins N edges after the next write.
    task automatic push_frame(input int base, input int sel, input logic first, input int cnt);
        exp_t e;
        int p;
        for (int j = 0; j < cnt; j++) begin
            p = (sel == 1) ? rot_t[j] : (sel == 2) ? rev_t[j] : j;
            e.n    = drv_cnt + N + j;
            e.dor  = 16'(base + p);
            e.doi  = 16'(base + 100 + p);
            e.oidx = 4'(p);
            e.rdy  = first && (j == 0);
            sb.push_back(e);
        end
    endtask

    task automatic write_frame(input int base, input logic [1:0] md_lo, input logic [1:0] md_hi,
                               input logic gap, input int cnt);
        logic [1:0] md;
        for (int w = 0; w < cnt; w++) begin
            md = (w < 8) ? md_lo : md_hi;
            if (gap) begin
                cyc(1'b0, 1'b0, 1'b0, md, 16'hffff, 16'hffff);
                cyc(1'b0, 1'b0, 1'b0, md, 16'hffff, 16'hffff);
            end
            cyc(1'b1, 1'b0, 1'b0, md, base + w, base + 100 + w);
        end
    endtask

    // Monitor: samples controls at the edge, compares outputs 1 time unit later.
    initial begin : monitor
        logic ed_s, st_s, rs_s;
        logic known;
        logic [15:0] kdor, kdoi;
        logic [3:0] koidx;
        exp_t e;
        int idx;
        known = 1'b0; kdor = '0; kdoi = '0; koidx = '0;
        forever begin
            @(posedge CLK);
            ed_s = ED; st_s = START; rs_s = RST;
            #1;
            if (rs_s) begin
                check("reset", {RDY, DOR, DOI, OIDX}, 37'b0);
                known = 1'b1; kdor = '0; kdoi = '0; koidx = '0;
            end else if (!ed_s || st_s) begin
                if (known) check("hold", {RDY, DOR, DOI, OIDX}, {1'b0, kdor, kdoi, koidx});
                else check("rdy_low", {36'b0, RDY}, 37'b0);
            end else begin
                idx = mon_cnt;
                mon_cnt++;
                while (sb.size() > 0 && sb[0].n < idx) begin
                    e = sb.pop_front();
                    check($sformatf("missed_out[%0d]", e.n), 37'(idx), 37'(e.n));
                end
                if (sb.size() > 0 && sb[0].n == idx) begin
                    e = sb.pop_front();
                    check($sformatf("out[%0d]", idx), {RDY, DOR, DOI, OIDX},
                          {e.rdy, e.dor, e.doi, e.oidx});
                    known = 1'b1; kdor = e.dor; kdoi = e.doi; koidx = e.oidx;
                end else begin
                    check($sformatf("rdy_low[%0d]", idx), {36'b0, RDY}, 37'b0);
                    known = 1'b0;
                end
            end
            if (RDY === 1'b1) rdy_seen++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        RST = 1'b1; ED = 1'b0; START = 1'b0; MODE = 2'd0; DR = '0; DI = '0;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 2'd0, 0, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);

        // START with ED high: data on this cycle must be discarded.
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 16'hdead, 16'hbeef);
        push_frame(0, 1, 1'b1, 16);
        write_frame(0, 2'd1, 2'd1, 1'b0, 16);
        push_frame(32, 2, 1'b0, 16);
        write_frame(32, 2'd2, 2'd2, 1'b0, 16);
        // Gapped frame, natural order; frame-1 bit-reversed readout is gapped too.
        push_frame(64, 0, 1'b0, 16);
        write_frame(64, 2'd0, 2'd0, 1'b1, 16);
        // Mode switches 0 -> 2 mid-frame; value at the last write decides.
        push_frame(96, 2, 1'b0, 5);
        write_frame(96, 2'd0, 2'd2, 1'b0, 16);
        // Reserved mode, partial frame abandoned by START at w=5.
        write_frame(128, 2'd3, 2'd3, 1'b0, 5);
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 16'h1234, 16'h5678);
        push_frame(200, 1, 1'b1, 16);
        write_frame(200, 2'd1, 2'd1, 1'b0, 16);
        write_frame(300, 2'd0, 2'd0, 1'b0, 16);

        // Reset together with START and ED, then run without START: no RDY.
        cyc(1'b1, 1'b1, 1'b1, 2'd2, 16'h0bad, 16'h0bad);
        write_frame(500, 2'd0, 2'd0, 1'b0, 16);
        write_frame(520, 2'd0, 2'd0, 1'b0, 16);
        write_frame(540, 2'd0, 2'd0, 1'b0, 8);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 0, 0);
        push_frame(400, 0, 1'b1, 1);
        write_frame(400, 2'd0, 2'd0, 1'b0, 16);
        write_frame(450, 2'd0, 2'd0, 1'b0, 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
        @(negedge CLK);

        check("sb_empty", 37'(sb.size()), 37'd0);
        check("rdy_pulses", 37'(rdy_seen), 37'd3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
